pcs_rx_lock_mgr: RTL and testbench
==================================

PCS_RX_LOCK_MGR -- requirements
Module: pcs_rx_lock_mgr

Interface
REQ-001 SHALL have parameter P_LANES, 2, number of independent PCS receive lanes (1..8).
REQ-002 SHALL have parameter P_TMO_W, 26, width of the per-lane timeout counter.
REQ-003 SHALL have parameter P_TMO, 26'h3ffff00, number of unsynced cycles before a lane reset is issued.
REQ-004 SHALL have parameter P_RST_LEN, 16, o_pcs_rst pulse length in cycles (>=2).
REQ-005 SHALL have parameter P_HYST, 255, number of consecutive synced cycles required to declare lock (>=1).
REQ-006 SHALL have parameter P_MAX_RETRY, 7, number of consecutive resets before a lane is declared failed (1..15).
REQ-007 SHALL have port i_local_clk, input, 1, the single clock; all logic runs in this domain.
REQ-008 SHALL have port i_rst_n, input, 1, asynchronous active-low reset.
REQ-009 SHALL have port i_syn, input, P_LANES, per-lane sync flag from the unpacker; asynchronous to i_local_clk.
REQ-010 SHALL have port i_clr, input, 1, single-cycle pulse that clears fail flags and statistics.
REQ-011 SHALL have port o_pcs_lock, output, P_LANES, per-lane qualified lock.
REQ-012 SHALL have port o_pcs_rst, output, P_LANES, per-lane PCS reset request, active-high.
REQ-013 SHALL have port o_all_lock, output, 1, AND of all o_pcs_lock bits.
REQ-014 SHALL have port o_fail, output, P_LANES, per-lane sticky retry-exhausted flag.
REQ-015 SHALL have port o_loss_cnt, output, 16*P_LANES, per-lane loss-of-lock counters; present only with PCS_LOCK_STATS_EN.

Function
REQ-016 SHALL pass each i_syn bit through a 2-flop synchroniser before use (syn_s); input-to-FSM latency is 2 cycles.
REQ-017 SHALL run one FSM per lane with the states WAIT, QUAL, LOCK and RST, plus a P_TMO_W-bit counter cnt.
REQ-018 In WAIT: syn_s=1 -> QUAL with cnt=0; otherwise cnt increments, and cnt==P_TMO-1 -> RST with cnt=0.
REQ-019 In QUAL: syn_s=0 -> WAIT with cnt=0; cnt==P_HYST-1 with syn_s=1 -> LOCK.
REQ-020 In LOCK: syn_s=0 -> WAIT with cnt=0, and the lane's loss counter increments.
REQ-021 In RST: o_pcs_rst=1 and syn_s is ignored; cnt==P_RST_LEN-1 -> WAIT with cnt=0.
REQ-022 The 4-bit retry counter SHALL increment (saturating at 15) on each entry to RST and clear on entry to LOCK.
REQ-023 o_fail[n] SHALL set when retry reaches P_MAX_RETRY and stay set until i_clr; resets continue to be issued while failed.
REQ-024 o_pcs_lock and o_pcs_rst SHALL be registered and decoded from state: lock=(state==LOCK), rst=(state==RST).
REQ-025 i_clr SHALL clear o_fail, retry and loss counters in the next cycle and SHALL win over a simultaneous increment or set.
REQ-026 Loss counters SHALL saturate at 16'hFFFF.
REQ-027 Lanes SHALL be fully independent; o_all_lock SHALL be registered, one cycle after the o_pcs_lock bits.

Reset
REQ-028 Asserting i_rst_n low at any time, including mid-RST pulse, SHALL immediately force: state=WAIT, cnt=0, retry=0, synchronisers=0, and o_pcs_lock, o_pcs_rst, o_all_lock, o_fail and o_loss_cnt all to 0.
REQ-029 Deassertion SHALL be synchronised by the system; after release, each lane starts in WAIT.

Configuration
REQ-030 Macro PCS_LOCK_STATS_EN defined: the loss counters and the o_loss_cnt port SHALL exist.
REQ-031 Macro PCS_LOCK_STATS_EN undefined: the counters and the port SHALL be absent, with all other behaviour identical.

Structure
REQ-032 Package pcs_rx_pkg SHALL hold the lane state encoding (WAIT=2'd0, QUAL=2'd1, LOCK=2'd2, RST=2'd3) and the loss counter width constant (16).
REQ-033 The per-lane FSM, counters and synchroniser SHALL be sub-module pcs_lane_lock_fsm, instantiated P_LANES times by a generate loop; the top holds only the aggregation logic.

Verification (P_TMO=100, P_HYST=8, P_RST_LEN=4, P_MAX_RETRY=3 for the bench)
REQ-034 Lane0 i_syn held at 1 from reset release -> o_pcs_lock[0]=1 exactly 2+8+1 cycles later; o_pcs_rst[0] never asserts.
REQ-035 Lane1 i_syn held at 0 -> o_pcs_rst[1] pulses high for 4 cycles every 104 cycles; o_fail[1]=1 on the 3rd pulse.
REQ-036 Lane0 locked, then i_syn low for 1 cycle -> o_pcs_lock[0] drops; o_loss_cnt[15:0]=1; relock occurs after 8 synced cycles.
REQ-037 i_syn toggles every 5 cycles -> the lane never reaches LOCK and never reaches RST (cnt restarts each time).
REQ-038 i_clr asserted in the same cycle as a loss event -> o_loss_cnt=0 and o_fail=0 on the next cycle.
REQ-039 i_rst_n asserted during the 2nd cycle of an RST pulse -> o_pcs_rst=0 immediately; after release, the first reset occurs 100 cycles later.

Source files
------------

// File: rtl/pcs_rx_pkg.sv
// Shared lane-state encoding and widths for the PCS receive lock manager.
// The loss counter width applies only to builds with PCS_LOCK_STATS_EN.
package pcs_rx_pkg;

  typedef enum logic [1:0] {
    ST_WAIT = 2'd0,
    ST_QUAL = 2'd1,
    ST_LOCK = 2'd2,
    ST_RST  = 2'd3
  } lane_st_e;

  localparam int unsigned LOSS_CNT_W = 16;
  localparam int unsigned RETRY_W    = 4;

  function automatic logic [LOSS_CNT_W-1:0] loss_sat_inc(input logic [LOSS_CNT_W-1:0] v);
    return (&v) ? v : v + LOSS_CNT_W'(1);
  endfunction

endpackage

// File: rtl/pcs_lane_lock_fsm.sv
// One PCS lane: sync flag synchroniser, WAIT/QUAL/LOCK/RST FSM, retry and fail tracking.
// The loss-of-lock counter and its port exist only with PCS_LOCK_STATS_EN.
module pcs_lane_lock_fsm
  import pcs_rx_pkg::*;
#(
  parameter int unsigned          P_TMO_W     = 26,
  parameter logic [P_TMO_W-1:0]   P_TMO       = 26'h3ffff00,
  parameter int unsigned          P_RST_LEN   = 16,
  parameter int unsigned          P_HYST      = 255,
  parameter int unsigned          P_MAX_RETRY = 7
) (
  input  logic                  i_local_clk,
  input  logic                  i_rst_n,
  input  logic                  i_syn,
  input  logic                  i_clr,
  output logic                  o_lock,
  output logic                  o_rst,
  output logic                  o_fail
`ifdef PCS_LOCK_STATS_EN
  ,
  output logic [LOSS_CNT_W-1:0] o_loss_cnt
`endif
);

  localparam logic [P_TMO_W-1:0] TMO_LAST  = P_TMO - P_TMO_W'(1);
  localparam logic [P_TMO_W-1:0] HYST_LAST = P_TMO_W'(P_HYST - 1);
  localparam logic [P_TMO_W-1:0] RST_LAST  = P_TMO_W'(P_RST_LEN - 1);
  localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(P_MAX_RETRY);

  logic               syn_m_q;
  logic               syn_s_q;
  lane_st_e           state_q, state_d;
  logic [P_TMO_W-1:0] cnt_q, cnt_d;
  logic [RETRY_W-1:0] retry_q, retry_d;
  logic               fail_q, fail_d;
  logic               lock_q;
  logic               rst_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    retry_d = retry_q;
    fail_d  = fail_q;
    case (state_q)
      ST_WAIT: begin
        if (syn_s_q) begin
          state_d = ST_QUAL;
          cnt_d   = '0;
        end else if (cnt_q == TMO_LAST) begin
          state_d = ST_RST;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + P_TMO_W'(1);
        end
      end
      ST_QUAL: begin
        if (!syn_s_q) begin
          state_d = ST_WAIT;
          cnt_d   = '0;
        end else if (cnt_q == HYST_LAST) begin
          state_d = ST_LOCK;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + P_TMO_W'(1);
        end
      end
      ST_LOCK: begin
        if (!syn_s_q) begin
          state_d = ST_WAIT;
          cnt_d   = '0;
        end
      end
      ST_RST: begin
        if (cnt_q == RST_LAST) begin
          state_d = ST_WAIT;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + P_TMO_W'(1);
        end
      end
      default: begin
        state_d = ST_WAIT;
        cnt_d   = '0;
      end
    endcase

    // Retry counts consecutive resets; a successful lock proves the lane healthy again.
    if (state_d == ST_RST && state_q != ST_RST) begin
      retry_d = (&retry_q) ? retry_q : retry_q + RETRY_W'(1);
    end else if (state_d == ST_LOCK && state_q != ST_LOCK) begin
      retry_d = '0;
    end
    if (i_clr) begin
      retry_d = '0;
      fail_d  = 1'b0;
    end else if (retry_d >= RETRY_MAX) begin
      fail_d = 1'b1;
    end
  end

  always_ff @(posedge i_local_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      syn_m_q <= 1'b0;
      syn_s_q <= 1'b0;
      state_q <= ST_WAIT;
      cnt_q   <= '0;
      retry_q <= '0;
      fail_q  <= 1'b0;
      lock_q  <= 1'b0;
      rst_q   <= 1'b0;
    end else begin
      syn_m_q <= i_syn;
      syn_s_q <= syn_m_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      retry_q <= retry_d;
      fail_q  <= fail_d;
      lock_q  <= (state_d == ST_LOCK);
      rst_q   <= (state_d == ST_RST);
    end
  end

  assign o_lock = lock_q;
  assign o_rst  = rst_q;
  assign o_fail = fail_q;

`ifdef PCS_LOCK_STATS_EN
  logic                  loss_ev;
  logic [LOSS_CNT_W-1:0] loss_q, loss_d;

  assign loss_ev = (state_q == ST_LOCK) && !syn_s_q;

  always_comb begin
    loss_d = loss_q;
    if (i_clr) begin
      loss_d = '0;
    end else if (loss_ev) begin
      loss_d = loss_sat_inc(loss_q);
    end
  end

  always_ff @(posedge i_local_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      loss_q <= '0;
    end else begin
      loss_q <= loss_d;
    end
  end

  assign o_loss_cnt = loss_q;
`endif

endmodule

// File: rtl/pcs_rx_lock_mgr.sv
// Multi-lane PCS receive lock manager: one pcs_lane_lock_fsm per lane plus all-lane lock.
// Define PCS_LOCK_STATS_EN to add the per-lane loss-of-lock counters on o_loss_cnt.
module pcs_rx_lock_mgr
  import pcs_rx_pkg::*;
#(
  parameter int unsigned          P_LANES     = 2,
  parameter int unsigned          P_TMO_W     = 26,
  parameter logic [P_TMO_W-1:0]   P_TMO       = 26'h3ffff00,
  parameter int unsigned          P_RST_LEN   = 16,
  parameter int unsigned          P_HYST      = 255,
  parameter int unsigned          P_MAX_RETRY = 7
) (
  input  logic                          i_local_clk,
  input  logic                          i_rst_n,
  input  logic [P_LANES-1:0]            i_syn,
  input  logic                          i_clr,
  output logic [P_LANES-1:0]            o_pcs_lock,
  output logic [P_LANES-1:0]            o_pcs_rst,
  output logic                          o_all_lock,
  output logic [P_LANES-1:0]            o_fail
`ifdef PCS_LOCK_STATS_EN
  ,
  output logic [LOSS_CNT_W*P_LANES-1:0] o_loss_cnt
`endif
);

  logic [P_LANES-1:0] lock_w;
  logic [P_LANES-1:0] rst_w;
  logic [P_LANES-1:0] fail_w;
  logic               all_lock_q;

  for (genvar g = 0; g < P_LANES; g++) begin : g_lane
    pcs_lane_lock_fsm #(
      .P_TMO_W     (P_TMO_W),
      .P_TMO       (P_TMO),
      .P_RST_LEN   (P_RST_LEN),
      .P_HYST      (P_HYST),
      .P_MAX_RETRY (P_MAX_RETRY)
    ) u_lane (
      .i_local_clk (i_local_clk),
      .i_rst_n     (i_rst_n),
      .i_syn       (i_syn[g]),
      .i_clr       (i_clr),
      .o_lock      (lock_w[g]),
      .o_rst       (rst_w[g]),
      .o_fail      (fail_w[g])
`ifdef PCS_LOCK_STATS_EN
      ,
      .o_loss_cnt  (o_loss_cnt[g*LOSS_CNT_W +: LOSS_CNT_W])
`endif
    );
  end

  always_ff @(posedge i_local_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      all_lock_q <= 1'b0;
    end else begin
      all_lock_q <= &lock_w;
    end
  end

  assign o_pcs_lock = lock_w;
  assign o_pcs_rst  = rst_w;
  assign o_fail     = fail_w;
  assign o_all_lock = all_lock_q;

endmodule

// File: tb/tb_pcs_rx_lock_mgr.sv
// Scoreboard bench for pcs_rx_lock_mgr (TMO=100, HYST=8, RST_LEN=4, MAX_RETRY=3, 2 lanes).
// Expected outputs are derived from closed-form lane timing and queued per driven cycle.
module tb_pcs_rx_lock_mgr;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] syn   = 2'b00;
  logic       clr   = 1'b0;
  wire  [1:0] lock;
  wire  [1:0] prst;
  wire  [1:0] fail;
  wire        all_lock;
`ifdef PCS_LOCK_STATS_EN
  wire [31:0] loss_cnt;
`endif

  pcs_rx_lock_mgr #(
    .P_LANES     (2),
    .P_TMO_W     (26),
    .P_TMO       (26'd100),
    .P_RST_LEN   (4),
    .P_HYST      (8),
    .P_MAX_RETRY (3)
  ) dut (
    .i_local_clk (clk),
    .i_rst_n     (rst_n),
    .i_syn       (syn),
    .i_clr       (clr),
    .o_pcs_lock  (lock),
    .o_pcs_rst   (prst),
    .o_all_lock  (all_lock),
    .o_fail      (fail)
`ifdef PCS_LOCK_STATS_EN
    ,
    .o_loss_cnt  (loss_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]  lock;
    logic [1:0]  rst;
    logic        all;
    logic [1:0]  fail;
    logic [15:0] loss0;
    logic [15:0] loss1;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_chk  = 0;
  int   n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s @%0t: got %0h, want %0h", tag, $time, act, exp);
  endtask

  function automatic exp_t mk(input logic [1:0] lk, input logic [1:0] rs, input logic al,
                              input logic [1:0] fl, input logic [15:0] l0, input logic [15:0] l1);
    exp_t e;
    e.lock = lk; e.rst = rs; e.all = al; e.fail = fl; e.loss0 = l0; e.loss1 = l1;
    return e;
  endfunction

  always @(posedge clk) begin
    #1;
    if (sb.size() != 0) begin
      mon_e = sb.pop_front();
      chk("lock", {30'd0, lock}, {30'd0, mon_e.lock});
      chk("pcs_rst", {30'd0, prst}, {30'd0, mon_e.rst});
      chk("all_lock", {31'd0, all_lock}, {31'd0, mon_e.all});
      chk("fail", {30'd0, fail}, {30'd0, mon_e.fail});
`ifdef PCS_LOCK_STATS_EN
      chk("loss0", {16'd0, loss_cnt[15:0]}, {16'd0, mon_e.loss0});
      chk("loss1", {16'd0, loss_cnt[31:16]}, {16'd0, mon_e.loss1});
`endif
    end
  end

  // Called at a falling edge: drive inputs for the next rising edge and queue its result.
  task automatic cyc(input logic [1:0] s, input logic c, input exp_t e);
    syn = s;
    clr = c;
    sb.push_back(e);
    @(negedge clk);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_lock"}, {30'd0, lock}, 32'd0);
    chk({tag, "_rst"}, {30'd0, prst}, 32'd0);
    chk({tag, "_all"}, {31'd0, all_lock}, 32'd0);
    chk({tag, "_fail"}, {30'd0, fail}, 32'd0);
`ifdef PCS_LOCK_STATS_EN
    chk({tag, "_loss"}, loss_cnt, 32'd0);
`endif
  endtask

  // After release: lane0 syn=1 locks at edge 11; lane1 syn=0 resets at 100 + 104*n for 4 cycles.
  task automatic run_fresh(input int n);
    logic l0, r1, f1;
    for (int k = 1; k <= n; k++) begin
      l0 = (k >= 11);
      r1 = (k >= 100) && (((k - 100) % 104) < 4);
      f1 = (k >= 308);
      cyc(2'b01, 1'b0, mk({1'b0, l0}, {r1, 1'b0}, 1'b0, {f1, 1'b0}, 16'd0, 16'd0));
    end
  endtask

  // Both lanes locked; lane0 syn drops for one cycle, optionally with i_clr on the loss edge.
  task automatic run_glitch(input logic do_clr);
    logic       l0, al;
    logic [1:0] fl;
    logic [15:0] ls;
    for (int j = 1; j <= 16; j++) begin
      l0 = !(j >= 3 && j <= 11);
      al = !(j >= 4 && j <= 12);
      if (do_clr) begin
        fl = (j >= 3) ? 2'b00 : 2'b10;
        ls = (j >= 3) ? 16'd0 : 16'd1;
      end else begin
        fl = 2'b10;
        ls = (j >= 3) ? 16'd1 : 16'd0;
      end
      cyc((j == 1) ? 2'b10 : 2'b11, do_clr && (j == 3), mk({1'b1, l0}, 2'b00, al, fl, ls, 16'd0));
    end
  endtask

  initial begin
    logic s0;
    syn = 2'b01;
    repeat (2) @(negedge clk);
    check_zero("reset");
    repeat (3) @(negedge clk);
    check_zero("reset_hold");
    rst_n = 1'b1;
    run_fresh(420);

    for (int j = 1; j <= 20; j++) begin
      cyc(2'b11, 1'b0, mk({(j >= 11), 1'b1}, 2'b00, (j >= 12), 2'b10, 16'd0, 16'd0));
    end
    run_glitch(1'b0);
    run_glitch(1'b1);

    for (int j = 1; j <= 300; j++) begin
      s0 = (((j - 1) / 5) % 2) == 1;
      cyc({1'b1, s0}, 1'b0, mk({1'b1, (j <= 2)}, 2'b00, (j <= 3), 2'b00,
                              (j >= 3) ? 16'd1 : 16'd0, 16'd0));
    end

    rst_n = 1'b0;
    #1;
    check_zero("reset2");
    syn = 2'b01;
    @(negedge clk);
    rst_n = 1'b1;
    run_fresh(101);
    chk("rst_pre", {30'd0, prst}, 32'd2);
    rst_n = 1'b0;
    #1;
    check_zero("reset_mid_pulse");
    @(negedge clk);
    rst_n = 1'b1;
    run_fresh(110);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
